alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU (add/sub/and/or/xor/slt/sll/srl, 3-bit alucontrol) between two requesters.

---
 rtl/alu_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Requester 0 is the PC/address-increment path, requester 1 the execute path.
// Each operation runs IDLE (grant) -> EXEC (ALU evaluates) -> HOLD (result
// parked in the owner's response register until the owner consumes it).
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0 request channel
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  // requester 0 response channel
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_lt,
  // requester 1 request channel
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  // requester 1 response channel
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_lt,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_lt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr_ptr;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_ctrl;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result [2];
  logic [1:0]       r_rsp_zero;
  logic [1:0]       r_rsp_lt;

  logic             w_gnt_any;
  logic             w_gnt;
  logic             w_owner_rsp_ready;

  // Grant selection: only meaningful in IDLE and never while reset is held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_gnt_any = 1'b0;
    w_gnt     = 1'b0;
    if (r_state == IDLE && !reset) begin
      w_gnt_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
        w_gnt = PRIO_FIXED ? 1'b0 : r_rr_ptr;
      end else begin
        w_gnt = req1_valid;
      end
    end
  end

  assign w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  // Next-state logic for the grant/execute/hold sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_any) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = HOLD;
      HOLD:    if (w_owner_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand capture and round-robin pointer update on an accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_ctrl   <= '0;
      r_owner  <= 1'b0;
      r_rr_ptr <= 1'b0;
    end else if (w_gnt_any) begin
      r_a      <= w_gnt ? req1_a    : req0_a;
      r_b      <= w_gnt ? req1_b    : req0_b;
      r_ctrl   <= w_gnt ? req1_ctrl : req0_ctrl;
      r_owner  <= w_gnt;
      r_rr_ptr <= ~w_gnt;
    end
  end

  // Response registers: captured from the ALU at the end of EXEC, released on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the result array is reset explicitly because the response outputs must read 0 out of reset.
      r_rsp_result[0] <= '0;
      r_rsp_result[1] <= '0;
      r_rsp_valid     <= '0;
      r_rsp_zero      <= '0;
      r_rsp_lt        <= '0;
    end else begin
      case (r_state)
        EXEC: begin
          r_rsp_result[r_owner] <= alu_result;
          r_rsp_zero[r_owner]   <= alu_zero;
          r_rsp_lt[r_owner]     <= alu_lt;
          r_rsp_valid[r_owner]  <= 1'b1;
        end
        HOLD: if (w_owner_rsp_ready) r_rsp_valid[r_owner] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req0_ready  = w_gnt_any & ~w_gnt;
  assign req1_ready  = w_gnt_any &  w_gnt;

  assign rsp0_valid  = r_rsp_valid[0];
  assign rsp0_result = r_rsp_result[0];
  assign rsp0_zero   = r_rsp_zero[0];
  assign rsp0_lt     = r_rsp_lt[0];
  assign rsp1_valid  = r_rsp_valid[1];
  assign rsp1_result = r_rsp_result[1];
  assign rsp1_zero   = r_rsp_zero[1];
  assign rsp1_lt     = r_rsp_lt[1];

  // The ALU inputs always come straight from registers, so they never glitch.
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alucontrol = r_ctrl;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin instance and a fixed-priority
// instance share the same requester stimulus. A transaction-level model per
// instance is compared with the outputs on every falling edge; directed
// scenarios add literal expectations on top.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         v0, v1, rr0, rr1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   c0, c1;

  logic         rdy0 [2], rdy1 [2], rv0 [2], rv1 [2];
  logic         z0 [2], z1 [2], l0 [2], l1 [2], bsy [2];
  logic [W-1:0] res0 [2], res1 [2], alu_a [2], alu_b [2], alu_r [2];
  logic [2:0]   alu_c [2];
  logic         alu_z [2], alu_l [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_alu
    assign alu_r[k] = alu_f(alu_a[k], alu_b[k], alu_c[k]);
    assign alu_z[k] = (alu_r[k] == '0);
    assign alu_l[k] = alu_r[k][W-1];
  end

  alu_share_arbiter #(.WIDTH(W), .PRIO_FIXED(1'b0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(rdy0[0]), .req0_a(a0), .req0_b(b0), .req0_ctrl(c0),
    .rsp0_valid(rv0[0]), .rsp0_ready(rr0), .rsp0_result(res0[0]), .rsp0_zero(z0[0]), .rsp0_lt(l0[0]),
    .req1_valid(v1), .req1_ready(rdy1[0]), .req1_a(a1), .req1_b(b1), .req1_ctrl(c1),
    .rsp1_valid(rv1[0]), .rsp1_ready(rr1), .rsp1_result(res1[0]), .rsp1_zero(z1[0]), .rsp1_lt(l1[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alucontrol(alu_c[0]),
    .alu_result(alu_r[0]), .alu_zero(alu_z[0]), .alu_lt(alu_l[0]), .busy(bsy[0])
  );

  alu_share_arbiter #(.WIDTH(W), .PRIO_FIXED(1'b1)) dut_fx (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(rdy0[1]), .req0_a(a0), .req0_b(b0), .req0_ctrl(c0),
    .rsp0_valid(rv0[1]), .rsp0_ready(rr0), .rsp0_result(res0[1]), .rsp0_zero(z0[1]), .rsp0_lt(l0[1]),
    .req1_valid(v1), .req1_ready(rdy1[1]), .req1_a(a1), .req1_b(b1), .req1_ctrl(c1),
    .rsp1_valid(rv1[1]), .rsp1_ready(rr1), .rsp1_result(res1[1]), .rsp1_zero(z1[1]), .rsp1_lt(l1[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alucontrol(alu_c[1]),
    .alu_result(alu_r[1]), .alu_zero(alu_z[1]), .alu_lt(alu_l[1]), .busy(bsy[1])
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: at most one operation in flight per instance.
  // m_age counts edges since the accepting edge; the result is visible from age 2.
  bit           m_busy [2];
  int           m_age  [2];
  bit           m_own  [2];
  bit           m_pref [2];
  logic [W-1:0] m_a [2], m_b [2];
  logic [2:0]   m_c [2];
  logic [W-1:0] m_res [2][2];
  bit           m_z [2][2], m_l [2][2];

  // Compare outputs with the model, then advance the model across the next rising edge.
  always @(negedge clk) begin : compare
    bit g, gany, e_rv0, e_rv1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0; m_age[k] = 0; m_own[k] = 1'b0; m_pref[k] = 1'b0;
        m_a[k] = '0; m_b[k] = '0; m_c[k] = '0;
        for (int n = 0; n < 2; n++) begin
          m_res[k][n] = '0; m_z[k][n] = 1'b0; m_l[k][n] = 1'b0;
        end
      end
      gany = !reset && !m_busy[k] && (v0 || v1);
      if (v0 && v1) g = (k == 1) ? 1'b0 : m_pref[k];
      else          g = v1;
      e_rv0 = m_busy[k] && m_age[k] >= 2 && !m_own[k];
      e_rv1 = m_busy[k] && m_age[k] >= 2 &&  m_own[k];
      check($sformatf("k%0d req0_ready", k), rdy0[k], gany && !g);
      check($sformatf("k%0d req1_ready", k), rdy1[k], gany && g);
      check($sformatf("k%0d rsp0_valid", k), rv0[k], e_rv0);
      check($sformatf("k%0d rsp1_valid", k), rv1[k], e_rv1);
      check($sformatf("k%0d busy", k), bsy[k], m_busy[k]);
      check($sformatf("k%0d alu_a", k), alu_a[k], m_a[k]);
      check($sformatf("k%0d alu_b", k), alu_b[k], m_b[k]);
      check($sformatf("k%0d alucontrol", k), alu_c[k], m_c[k]);
      if (e_rv0 || reset) begin
        check($sformatf("k%0d rsp0_result", k), res0[k], m_res[k][0]);
        check($sformatf("k%0d rsp0_zero", k), z0[k], m_z[k][0]);
        check($sformatf("k%0d rsp0_lt", k), l0[k], m_l[k][0]);
      end
      if (e_rv1 || reset) begin
        check($sformatf("k%0d rsp1_result", k), res1[k], m_res[k][1]);
        check($sformatf("k%0d rsp1_zero", k), z1[k], m_z[k][1]);
        check($sformatf("k%0d rsp1_lt", k), l1[k], m_l[k][1]);
      end
      if (!reset) begin
        if (m_busy[k]) begin
          if (m_age[k] == 1) begin
            m_age[k] = 2;
            m_res[k][m_own[k]] = alu_f(m_a[k], m_b[k], m_c[k]);
            m_z[k][m_own[k]]   = (m_res[k][m_own[k]] == '0);
            m_l[k][m_own[k]]   = m_res[k][m_own[k]][W-1];
          end else if (m_own[k] ? rr1 : rr0) begin
            m_busy[k] = 1'b0;
          end
        end else if (gany) begin
          m_busy[k] = 1'b1;
          m_age[k]  = 1;
          m_own[k]  = g;
          m_pref[k] = ~g;
          m_a[k]    = g ? a1 : a0;
          m_b[k]    = g ? b1 : b0;
          m_c[k]    = g ? c1 : c0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
  endtask

  // Wait (bounded) for the round-robin instance to raise req<n>_ready.
  task automatic wait_rdy(input int n);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (n == 1) ? rdy1[0] : rdy0[0];
    end
    if (!got) check($sformatf("wait req%0d_ready timeout", n), 0, 1);
  endtask

  // Wait (bounded) for the round-robin instance to raise rsp<n>_valid.
  task automatic wait_rv(input int n);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (n == 1) ? rv1[0] : rv0[0];
    end
    if (!got) check($sformatf("wait rsp%0d_valid timeout", n), 0, 1);
  endtask

  task automatic all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s k%0d busy", tag, k), bsy[k], 0);
      check($sformatf("%s k%0d rsp0_valid", tag, k), rv0[k], 0);
      check($sformatf("%s k%0d rsp1_valid", tag, k), rv1[k], 0);
      check($sformatf("%s k%0d rsp1_result", tag, k), res1[k], 0);
      check($sformatf("%s k%0d alu_a", tag, k), alu_a[k], 0);
      check($sformatf("%s k%0d alucontrol", tag, k), alu_c[k], 0);
      check($sformatf("%s k%0d ready", tag, k), {rdy1[k], rdy0[k]}, 0);
    end
  endtask

  initial begin : stim
    int order[$];
    int fx_rdy0, fx_rdy1, n_rsp0, n_rsp1, seen_rdy0, seen_rdy1, seen_rv1;
    reset = 1'b1;
    v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
    a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
    repeat (2) cyc();
    reset = 1'b0;

    // Reset state with no requests pending.
    @(negedge clk);
    check("reset req0_ready", rdy0[0], 0);
    check("reset busy", bsy[0], 0);
    check("reset rsp0_result", res0[0], 0);

    // Single add from requester 0: 5 + 7.
    cyc(); v0 = 1; a0 = 5; b0 = 7; c0 = 3'd0;
    wait_rdy(0);
    cyc(); v0 = 0;
    @(negedge clk);
    check("add exec busy", bsy[0], 1);
    check("add exec rsp0_valid", rv0[0], 0);
    @(negedge clk);
    check("add rsp0_valid", rv0[0], 1);
    check("add rsp0_result", res0[0], 32'd12);
    check("add rsp0_zero", z0[0], 0);
    check("add rsp0_lt", l0[0], 0);
    check("add rsp1_valid", rv1[0], 0);
    cyc(); rr0 = 1;
    @(negedge clk);
    @(negedge clk);
    check("add released rsp0_valid", rv0[0], 0);
    check("add released busy", bsy[0], 0);
    cyc(); rr0 = 0;

    // Both requesters valid every cycle: round-robin vs fixed priority.
    pulse_reset();
    v0 = 1; a0 = 3; b0 = 3; c0 = 3'd1;
    v1 = 1; a1 = 32'hFFFF_FFFF; b1 = 1; c1 = 3'd5;
    rr0 = 1; rr1 = 1;
    fx_rdy0 = 0; fx_rdy1 = 0; n_rsp0 = 0; n_rsp1 = 0;
    repeat (16) begin
      @(negedge clk);
      if (rdy0[0]) order.push_back(0);
      if (rdy1[0]) order.push_back(1);
      if (rv0[0]) begin
        n_rsp0++;
        check("sub rsp0_result", res0[0], 0);
        check("sub rsp0_zero", z0[0], 1);
      end
      if (rv1[0]) begin
        n_rsp1++;
        check("slt rsp1_result", res1[0], 1);
        check("slt rsp1_zero", z1[0], 0);
      end
      if (rdy0[1]) fx_rdy0++;
      if (rdy1[1]) fx_rdy1++;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("rr grant order[%0d]", i), (i < order.size()) ? order[i] : 99, i % 2);
    check("rr rsp0 seen", n_rsp0 >= 2, 1);
    check("rr rsp1 seen", n_rsp1 >= 2, 1);
    check("fixed req1_ready count", fx_rdy1, 0);
    check("fixed req0 grants", fx_rdy0 >= 4, 1);
    cyc(); v0 = 0; v1 = 0;
    repeat (4) @(negedge clk);

    // Backpressure on requester 1 after srl 0x80000000 >> 4.
    pulse_reset();
    v1 = 1; a1 = 32'h8000_0000; b1 = 4; c1 = 3'd7; rr0 = 0; rr1 = 0;
    wait_rdy(1);
    cyc(); v1 = 0; v0 = 1; a0 = 1; b0 = 2; c0 = 3'd0;
    wait_rv(1);
    repeat (4) begin
      check("bp rsp1_valid", rv1[0], 1);
      check("bp rsp1_result", res1[0], 32'h0800_0000);
      check("bp busy", bsy[0], 1);
      check("bp req0_ready", rdy0[0], 0);
      @(negedge clk);
    end
    cyc(); rr1 = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp released rsp1_valid", rv1[0], 0);
    check("bp req0 granted after", rdy0[0], 1);
    cyc(); v0 = 0; rr1 = 0; rr0 = 1;
    repeat (4) @(negedge clk);

    // Reset during EXEC.
    cyc(); rr0 = 0; v1 = 1; a1 = 32'h1234; b1 = 32'h10; c1 = 3'd3;
    wait_rdy(1);
    cyc(); v1 = 0;
    #2 reset = 1;
    #1 all_zero("rst exec");
    @(posedge clk); #1 reset = 0;

    // Reset during HOLD, then a tie must go to requester 0.
    v1 = 1;
    wait_rdy(1);
    cyc(); v1 = 0;
    wait_rv(1);
    @(posedge clk); #3 reset = 1;
    #1 all_zero("rst hold");
    @(posedge clk); #1 reset = 0; v0 = 1; v1 = 1; a0 = 9; b0 = 9; c0 = 3'd4;
    @(negedge clk);
    check("post-reset tie req0_ready", rdy0[0], 1);
    check("post-reset tie req1_ready", rdy1[0], 0);
    cyc(); v0 = 0; v1 = 0; rr0 = 1;
    repeat (4) @(negedge clk);

    // Requester 1 raises then drops valid while requester 0's result is held.
    cyc(); rr0 = 0; v0 = 1; a0 = 32'h40; b0 = 32'h2; c0 = 3'd6;
    wait_rdy(0);
    cyc(); v0 = 0;
    wait_rv(0);
    seen_rdy0 = 0; seen_rdy1 = 0; seen_rv1 = 0;
    cyc(); v1 = 1; a1 = 32'h77; b1 = 32'h1; c1 = 3'd1;
    cyc();
    cyc(); v1 = 0; v0 = 1; a0 = 32'h5; b0 = 32'h5; c0 = 3'd1; rr0 = 1;
    repeat (10) begin
      @(negedge clk);
      if (rdy0[0]) seen_rdy0++;
      if (rdy1[0]) seen_rdy1++;
      if (rv1[0])  seen_rv1++;
    end
    check("drop req0 served", seen_rdy0 >= 1, 1);
    check("drop req1_ready", seen_rdy1, 0);
    check("drop rsp1_valid", seen_rv1, 0);
    cyc(); v0 = 0;
    repeat (4) @(negedge clk);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset = ($urandom_range(0, 199) == 0);
      v0  = $urandom_range(0, 1);
      v1  = $urandom_range(0, 1);
      rr0 = ($urandom_range(0, 9) < 7);
      rr1 = ($urandom_range(0, 9) < 7);
      a0  = $urandom;
      a1  = $urandom;
      b0  = $urandom_range(0, 3) == 0 ? a0 : $urandom;
      b1  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 31)) : $urandom;
      c0  = 3'($urandom_range(0, 7));
      c1  = 3'($urandom_range(0, 7));
    end
    cyc(); reset = 0; v0 = 0; v1 = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
